// File: rtl/pipe_pkg.sv
// Shared constants for the control/destination pipeline queue.
// ZERO_REG is the architectural zero register, which never creates a hazard.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_REGW  = 5;

  localparam logic [4:0] ZERO_REG = 5'd31;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// One pipeline stage holding {valid, regwrite, rd, data}.
// Priority is reset > clear > load > hold; clear drops only the valid bit.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REGW  = DEF_REGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             d_valid,
  input  logic             d_regwrite,
  input  logic [REGW-1:0]  d_rd,
  input  logic [WIDTH-1:0] d_data,
  output logic             valid,
  output logic             valid_next,
  output logic             regwrite,
  output logic [REGW-1:0]  rd,
  output logic [WIDTH-1:0] data
);

  // valid_next is exported so the top can count next-state occupancy.
  // NOTE: assign a default at the top of every always_comb so no path leaves it unassigned (avoids a latch).
  always_comb begin
    valid_next = valid;
    if (clear)     valid_next = 1'b0;
    else if (load) valid_next = d_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      rd       <= '0;
      data     <= '0;
    end else begin
      valid <= valid_next;
      // Payload still moves on a flushing shift; only the valid bit is dropped.
      if (load) begin
        regwrite <= d_regwrite;
        rd       <= d_rd;
        data     <= d_data;
      end
    end
  end

endmodule : pipe_stage_reg

// File: rtl/ctrl_pipe_queue.sv
// Control/destination queue travelling alongside the datapath stages, with
// per-stage valids, global stall, partial flush and register-hazard lookup.
module ctrl_pipe_queue
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned REGW         = DEF_REGW,
  parameter int unsigned FLUSH_STAGES = 2,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_regwrite,
  input  logic [REGW-1:0]  in_rd,
  input  logic             stall,
  input  logic             flush,
  input  logic [REGW-1:0]  src_a,
  input  logic [REGW-1:0]  src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_regwrite,
  output logic [REGW-1:0]  out_rd,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [CW-1:0]    dist_a,
  output logic [CW-1:0]    dist_b,
  output logic [CW-1:0]    occupancy
);

  localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

  logic [DEPTH-1:0] st_valid;
  logic [DEPTH-1:0] st_valid_next;
  logic [DEPTH-1:0] st_regwrite;
  logic [REGW-1:0]  st_rd   [DEPTH];
  logic [WIDTH-1:0] st_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit FLUSHABLE = (i < FLUSH_STAGES);

    logic             d_valid;
    logic             d_regwrite;
    logic [REGW-1:0]  d_rd;
    logic [WIDTH-1:0] d_data;

    if (i == 0) begin : g_head
      assign d_valid    = in_valid;
      assign d_regwrite = in_regwrite;
      assign d_rd       = in_rd;
      assign d_data     = in_data;
    end else begin : g_body
      assign d_valid    = st_valid[i-1];
      assign d_regwrite = st_regwrite[i-1];
      assign d_rd       = st_rd[i-1];
      assign d_data     = st_data[i-1];
    end

    pipe_stage_reg #(
      .WIDTH (WIDTH),
      .REGW  (REGW)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .load       (!stall),
      .clear      (flush && FLUSHABLE),
      .d_valid    (d_valid),
      .d_regwrite (d_regwrite),
      .d_rd       (d_rd),
      .d_data     (d_data),
      .valid      (st_valid[i]),
      .valid_next (st_valid_next[i]),
      .regwrite   (st_regwrite[i]),
      .rd         (st_rd[i]),
      .data       (st_data[i])
    );
  end

  assign out_valid    = st_valid[DEPTH-1];
  assign out_regwrite = st_valid[DEPTH-1] & st_regwrite[DEPTH-1];
  assign out_rd       = st_rd[DEPTH-1];
  assign out_data     = st_data[DEPTH-1];

  // Lowest set index wins so the youngest in-flight writer is reported.
  function automatic logic [CW-1:0] youngest(input logic [DEPTH-1:0] m);
    logic [CW-1:0] d;
    d = CW'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m[i]) d = CW'(i);
    end
    return d;
  endfunction

  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = st_valid[i] & st_regwrite[i] & (st_rd[i] == src_a) & (src_a != ZR);
      match_b[i] = st_valid[i] & st_regwrite[i] & (st_rd[i] == src_b) & (src_b != ZR);
    end
  end

  assign hazard_a = |match_a;
  assign hazard_b = |match_b;
  assign dist_a   = youngest(match_a);
  assign dist_b   = youngest(match_b);

  logic [CW-1:0] occ_next;

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + CW'(st_valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) occupancy <= '0;
    else       occupancy <= occ_next;
  end

endmodule : ctrl_pipe_queue

// File: doc/ctrl_pipe_queue.md
# ctrl_pipe_queue

Parametrised control/destination queue that carries decoded control bits and destination-register tags alongside the datapath stages. It replaces the fixed per-stage control queues. It adds per-stage valid bits, a global stall, partial flush of the younger stages, and register-hazard lookup. The decoder feeds stage 0; the oldest stage drives register-file writeback control.

## Interface
Parameters:
- WIDTH, 16: control payload bits per stage (ALU control, memory enables, write-data select, etc.).
- DEPTH, 4: number of stages, minimum 1; stage 0 is youngest, stage DEPTH-1 is oldest.
- REGW, 5: register-address width.
- FLUSH_STAGES, 2: number of youngest stages (0..FLUSH_STAGES-1) cleared by flush; range 0..DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  stage-0 input carries a real instruction.
- in_data  in  WIDTH  control payload.
- in_regwrite  in  1  instruction writes a register.
- in_rd  in  REGW  destination register.
- stall  in  1  hold every stage this cycle.
- flush  in  1  squash stages 0..FLUSH_STAGES-1 and drop the current input.
- src_a, src_b  in  REGW  source registers to check for hazards.
- out_valid  out  1  oldest stage is valid.
- out_data  out  WIDTH  oldest-stage payload.
- out_regwrite  out  1  oldest-stage regwrite, gated by valid.
- out_rd  out  REGW  oldest-stage destination.
- hazard_a, hazard_b  out  1  the source matches a pending in-flight write.
- dist_a, dist_b  out  $clog2(DEPTH+1)  index of the youngest matching stage; DEPTH when there is no match.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.

## Operation
- Each stage holds {valid, regwrite, rd, data}.
- Normal cycle (no stall, no flush):
  - stage[i] <= stage[i-1]
  - stage[0] <= {in_valid, in_regwrite, in_rd, in_data}
- stall=1, flush=0: every stage holds and the input is ignored. The upstream block must hold its instruction.
- flush=1, stall=0: shift as normal, then force valid=0 in stages 0..FLUSH_STAGES-1. The input is therefore dropped.
- flush=1, stall=1: no shift; stages 0..FLUSH_STAGES-1 are cleared and the remaining stages hold. Flush takes priority over stall for the flushed stages.
- Invalidated stages keep their data bits (don't-care) but contribute nothing to outputs, hazards or occupancy.
- out_regwrite = valid & regwrite of stage DEPTH-1. out_data and out_rd pass through unmasked.
- Hazard match for a source s at stage i: valid & regwrite & rd==s & s!=ZERO_REG.
  - hazard_x = OR of matches over all stages.
  - dist_x = lowest matching i (the youngest writer wins).
- occupancy is a register equal to the popcount of the next-state valid vector, updated on the same edge as the valids.

## Timing
- Latency: an instruction accepted at edge N appears at the output after edge N+DEPTH-1, assuming no stalls. Each stalled cycle adds 1.
- Hazard and dist outputs are combinational from stage registers and src inputs, valid in the same cycle.
- Reset (synchronous, on any edge with reset=1): all valid, regwrite, rd and data bits are 0, and occupancy is 0.
  - Outputs after reset: out_valid=0, out_regwrite=0, hazards 0, dist=DEPTH.
  - Reset overrides stall and flush, including mid-stall.
- DEPTH=1: stage 0 is also the oldest stage. Flush with FLUSH_STAGES=1 empties it.
- FLUSH_STAGES=0: flush is ignored.

## Structure
- Shared package pipe_pkg holds ZERO_REG = 5'd31 (XZR never hazards) and the default WIDTH/DEPTH constants.
- One sub-module, pipe_stage_reg: a single stage with load, hold and clear controls. It is instantiated DEPTH times in a generate loop.
- Hazard priority encoding and occupancy popcount live in the top level.

## Test plan
- Reset, then in_valid=1, rd=3, regwrite=1, data=16'hA5A5 for one cycle (DEPTH=4) → out_valid=1, out_rd=3, out_data=A5A5 three edges later; occupancy goes 1,1,1,1 then 0 once the instruction leaves.
- Fill with rd=1,2,3,4 and hold stall=1 for 3 cycles → outputs are frozen, occupancy stays 4, and rd=4 exits 3 cycles later than it would without the stall.
- Full queue, flush=1 with FLUSH_STAGES=2 → stages 0–1 become invalid, occupancy drops from 4 to 2, and the older two drain normally.
- Stages hold rd=5 at index 1 and rd=5 at index 3; src_a=5 → hazard_a=1, dist_a=1. With src_b=31 and a stage writing X31 → hazard_b=0, dist_b=4.
- flush and stall together on a full queue → stages 0–1 are cleared, stages 2–3 are unchanged, and occupancy is 2.
- reset asserted mid-stall with 3 valid stages → the next cycle shows occupancy 0, out_valid=0, all hazards 0.
